// File: rtl/imem_loader.sv
// Framed byte-stream loader for the byte-wide, big-endian instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to compile in the trailing checksum byte and its check.
module imem_loader #(
  parameter int         ADDR_W    = 16,
  parameter int         MEM_BYTES = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // The bound checks are done at 9 bits so that A + L cannot wrap.
  localparam logic [8:0] MEM_LIM = 9'(MEM_BYTES);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_PAYLOAD = S_CSUM;
`else
  localparam state_t S_AFTER_PAYLOAD = S_DONE;
`endif

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] addr_cnt_r;
  logic [7:0]        start_r;
  logic [7:0]        remain_r;
  logic              in_ready_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              in_ready_s;
  logic              wr_en_s;
  logic              busy_s;
  logic              done_s;
  logic              err_s;
  logic              accept_s;
  logic              sync_hit_s;
  logic [8:0]        frame_end_s;

  assign accept_s    = in_valid && in_ready_r;
  assign sync_hit_s  = (state_r == S_IDLE) && accept_s && (in_byte == SYNC_BYTE);
  assign frame_end_s = {1'b0, start_r} + {1'b0, in_byte};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_r;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode from the accepted byte.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (sync_hit_s) state_s = S_ADDR;
        else            state_s = S_IDLE;
      end
      S_ADDR: begin
        if (!accept_s)                         state_s = S_ADDR;
        else if ({1'b0, in_byte} >= MEM_LIM)   state_s = S_ERR;
        else                                   state_s = S_LEN;
      end
      S_LEN: begin
        if (!accept_s)                 state_s = S_LEN;
        else if (frame_end_s > MEM_LIM) state_s = S_ERR;
        else if (in_byte == 8'd0)      state_s = S_AFTER_PAYLOAD;
        else                           state_s = S_DATA;
      end
      S_DATA: begin
        if (accept_s && (remain_r == 8'd1)) state_s = S_AFTER_PAYLOAD;
        else                                state_s = S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (!accept_s)                             state_s = S_CSUM;
        else if (csum_add(sum_r, in_byte) == 8'h00) state_s = S_DONE;
        else                                       state_s = S_ERR;
      end
`endif
      S_DONE:  state_s = S_IDLE;
      S_ERR:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    wr_en_s    = 1'b0;
    err_s      = err_r;
    case (state_s)
      S_IDLE:  in_ready_s = 1'b1;
      S_ADDR:  in_ready_s = 1'b1;
      S_LEN:   in_ready_s = 1'b1;
      S_DATA:  in_ready_s = 1'b1;
      S_CSUM:  in_ready_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
    if (state_s != S_IDLE) busy_s = 1'b1;
    else                   busy_s = 1'b0;
    if (state_s == S_DONE) done_s = 1'b1;
    else                   done_s = 1'b0;
    if ((state_r == S_DATA) && accept_s) wr_en_s = 1'b1;
    else                                 wr_en_s = 1'b0;
    if (state_s == S_ERR)  err_s = 1'b1;
    else if (sync_hit_s)   err_s = 1'b0;
    else                   err_s = err_r;
  end

  // Frame datapath: start address, write address counter, remaining count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_cnt_r <= {ADDR_W{1'b0}};
      start_r    <= 8'd0;
      remain_r   <= 8'd0;
    end else if (accept_s) begin
      case (state_r)
        S_ADDR: begin
          start_r    <= in_byte;
          addr_cnt_r <= ADDR_W'(in_byte);
        end
        S_LEN:   remain_r <= in_byte;
        S_DATA: begin
          addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
          remain_r   <= remain_r - 8'd1;
        end
        default: remain_r <= remain_r;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running modulo-256 sum of A, L and payload; the sync byte is excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_r <= 8'd0;
    end else if (accept_s) begin
      case (state_r)
        S_ADDR:  sum_r <= in_byte;
        S_LEN:   sum_r <= csum_add(sum_r, in_byte);
        S_DATA:  sum_r <= csum_add(sum_r, in_byte);
        default: sum_r <= sum_r;
      endcase
    end
  end
`endif

  // Output registers; address and data hold their last value between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      in_ready_r <= in_ready_s;
      wr_en_r    <= wr_en_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      if (wr_en_s) begin
        wr_addr_r <= addr_cnt_r;
        wr_data_r <= in_byte;
      end
    end
  end

  assign in_ready = in_ready_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level parser predicts every write and outcome.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W    = 16;
  localparam int MEM_BYTES = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NONE, K_SYNC, K_WR, K_WR_DONE, K_DONE, K_ERR} kind_t;
  typedef struct {
    kind_t      kind;
    int         addr;
    logic [7:0] data;
  } act_t;

  act_t       plan_q[$];
  int         n_checks = 0;
  int         n_errs   = 0;
  int         done_cnt = 0;
  int         wr_cnt   = 0;
  logic [7:0] mem[MEM_BYTES];
  int         wcount[MEM_BYTES];

  logic       e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_wr = 1'b0;
  logic       m_gap = 1'b0;
  int         e_addr = 0;
  logic [7:0] e_data = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_act(input kind_t k, input int a, input logic [7:0] d);
    act_t x;
    x.kind = k; x.addr = a; x.data = d;
    plan_q.push_back(x);
  endtask

  // Interpret a byte stream frame by frame; one planned action per byte.
  task automatic plan_stream(input logic [7:0] s[$]);
    int i, n, a, l, sum;
    i = 0; n = s.size();
    while (i < n) begin
      if (s[i] != 8'hA5) begin push_act(K_NONE, 0, 8'd0); i++; continue; end
      push_act(K_SYNC, 0, 8'd0); i++;
      if (i >= n) break;
      a = int'(s[i]);
      if (a >= MEM_BYTES) begin push_act(K_ERR, 0, 8'd0); i++; continue; end
      push_act(K_NONE, 0, 8'd0); i++;
      if (i >= n) break;
      l = int'(s[i]);
      if (a + l > MEM_BYTES) begin push_act(K_ERR, 0, 8'd0); i++; continue; end
      push_act((l == 0 && !CSUM) ? K_DONE : K_NONE, 0, 8'd0); i++;
      sum = a + l;
      for (int k = 0; k < l && i < n; k++) begin
        push_act((k == l - 1 && !CSUM) ? K_WR_DONE : K_WR, a + k, s[i]);
        sum += int'(s[i]); i++;
      end
      if (CSUM && i < n) begin
        sum += int'(s[i]);
        push_act((sum % 256 == 0) ? K_DONE : K_ERR, 0, 8'd0); i++;
      end
    end
  endtask

  // Per-cycle compare against the plan, plus the instruction-memory image.
  always @(negedge clk) begin : model
    act_t a;
    logic hs, term;
    if (!rst) begin
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_wr_addr", wr_addr, 16'h0000);
      chk("rst_wr_data", wr_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      plan_q.delete();
      e_ready <= 1'b0; e_busy <= 1'b0; e_done <= 1'b0; e_err <= 1'b0; e_wr <= 1'b0; m_gap <= 1'b0;
    end else begin
      chk("in_ready", in_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("wr_en", wr_en, e_wr);
      if (e_wr) begin
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
      end
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1;
        chk("wr_addr_range", int'(wr_addr) < MEM_BYTES, 1'b1);
        if (int'(wr_addr) < MEM_BYTES) begin
          mem[wr_addr]    <= wr_data;
          wcount[wr_addr] <= wcount[wr_addr] + 1;
        end
      end
      if (done) done_cnt <= done_cnt + 1;
      hs = in_valid && in_ready;
      a.kind = K_NONE; a.addr = 0; a.data = 8'd0;
      if (hs) begin
        chk("plan_avail", plan_q.size() > 0, 1'b1);
        if (plan_q.size() > 0) a = plan_q.pop_front();
      end
      term = hs && (a.kind == K_WR_DONE || a.kind == K_DONE || a.kind == K_ERR);
      e_wr    <= hs && (a.kind == K_WR || a.kind == K_WR_DONE);
      e_addr  <= a.addr;
      e_data  <= a.data;
      e_done  <= hs && (a.kind == K_WR_DONE || a.kind == K_DONE);
      e_ready <= !term;
      e_busy  <= (hs && a.kind == K_SYNC) ? 1'b1 : (m_gap ? 1'b0 : e_busy);
      e_err   <= (hs && a.kind == K_ERR) ? 1'b1 : ((hs && a.kind == K_SYNC) ? 1'b0 : e_err);
      m_gap   <= term;
    end
  end

  task automatic send(input logic [7:0] s[$], input bit gaps, input int max_n);
    int t;
    plan_stream(s);
    for (int i = 0; i < s.size() && i < max_n; i++) begin
      in_valid = 1'b1; in_byte = s[i]; t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      chk("handshake_wait", in_ready, 1'b1);
      if (!in_ready) begin in_valid = 1'b0; break; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gaps) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    @(negedge clk);
    for (int i = 0; i < MEM_BYTES; i++) begin mem[i] = 8'h00; wcount[i] = 0; end
    @(posedge clk); #1;
  endtask

  logic [7:0] q[$];
  int d0, w0;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin mem[i] = 8'h00; wcount[i] = 0; end
    rst = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    idle(3);
    rst = 1'b1;
    @(negedge clk); chk("ready_before_first_edge", in_ready, 1'b0);
    @(negedge clk); chk("ready_after_first_edge", in_ready, 1'b1);
    idle(1);

    // Basic load, then fetch at PC=4 reads big-endian 16'h1234.
    d0 = done_cnt; w0 = wr_cnt;
    q = {8'hA5, 8'h04, 8'h02, 8'h12, 8'h34, 8'hB4};
    send(q, 1'b0, 99); idle(4);
    chk("basic_done", done_cnt - d0, 1);
    chk("basic_writes", wr_cnt - w0, 2);
    chk("basic_err", err, 1'b0);
    chk("basic_fetch_pc4", {mem[4], mem[5]}, 16'h1234);

    // Bad checksum: writes stay, err flags the image.
    d0 = done_cnt; w0 = wr_cnt;
    q = {8'hA5, 8'h04, 8'h02, 8'h12, 8'h34, 8'h00};
    send(q, 1'b0, 99); idle(4);
    chk("badsum_done", done_cnt - d0, CSUM ? 0 : 1);
    chk("badsum_writes", wr_cnt - w0, 2);
    chk("badsum_err", err, CSUM);

    // Address out of range.
    w0 = wr_cnt;
    q = {8'hA5, 8'h40};
    send(q, 1'b0, 99);
    @(negedge clk); chk("addr_bound_err", err, 1'b1); chk("addr_bound_busy1", busy, 1'b1);
    @(negedge clk); chk("addr_bound_busy2", busy, 1'b0);
    idle(2);
    // Length runs past the end of memory.
    q = {8'hA5, 8'h3F, 8'h02};
    send(q, 1'b0, 99);
    @(negedge clk); chk("len_bound_err", err, 1'b1); chk("len_bound_ready", in_ready, 1'b0);
    @(negedge clk); chk("len_bound_busy2", busy, 1'b0);
    idle(2);
    chk("bound_no_writes", wr_cnt - w0, 0);

    // Leading junk then an empty frame.
    d0 = done_cnt; w0 = wr_cnt;
    q = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h10, 8'h00, 8'hF0};
    send(q, 1'b0, 99); idle(4);
    chk("empty_done", done_cnt - d0, 1);
    chk("empty_writes", wr_cnt - w0, 0);
    chk("empty_err_cleared", err, 1'b0);

    // Frame that ends exactly at the last memory byte.
    q = {8'hA5, 8'h3E, 8'h02, 8'hAA, 8'hBB, 8'h5B};
    send(q, 1'b0, 99); idle(4);
    chk("edge_mem62", mem[62], 8'hAA);
    chk("edge_mem63", mem[63], 8'hBB);

    // Backpressure: in_valid every other cycle.
    clear_mem();
    q = {8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h52};
    send(q, 1'b1, 99); idle(4);
    chk("bp_img", {mem[0], mem[1], mem[2], mem[3]}, 32'h11223344);
    for (int i = 0; i < 4; i++) chk("bp_write_once", wcount[i], 1);

    // Reset after the second payload byte, then a clean reload.
    clear_mem();
    q = {8'hA5, 8'h00, 8'h04, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    send(q, 1'b1, 5);
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);
    chk("rst_img", {mem[0], mem[1]}, 16'h5566);
    chk("rst_w0", wcount[0], 1);
    chk("rst_w1", wcount[1], 1);
    chk("rst_w2", wcount[2], 0);
    chk("rst_w3", wcount[3], 0);
    d0 = done_cnt;
    q = {8'hA5, 8'h08, 8'h03, 8'h01, 8'h02, 8'h03, 8'hEF};
    send(q, 1'b0, 99); idle(4);
    chk("reload_done", done_cnt - d0, 1);
    chk("reload_img", {mem[8], mem[9], mem[10]}, 24'h010203);
    chk("plan_drained", plan_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
